riscv_fetch_unit: RTL and testbench
===================================

Name: riscv_fetch_unit

Overview:
- Instruction fetch stage for the RISC-V core; the next generation of the fixed PC+4 counter.
- Owns the PC and issues in-order requests to instruction memory with a request/grant handshake, tolerating any response latency.
- Buffers returned instructions, each tagged with its PC, in a FIFO toward decode.
- Handles branch/jump redirects by flushing the FIFO and discarding stale in-flight responses.

Parameters:
BUS_WIDTH, 32, width of PC, address and instruction.
RESET_VECTOR, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
FIFO_DEPTH, 4, instruction buffer entries; power of two, minimum 2; also the cap on outstanding requests.

Ports:
i_CLK  in  1  clock; all state updates on rising edge.
i_RST_N  in  1  synchronous active-low reset.
o_IMEM_REQ  out  1  fetch request valid.
o_ADDR  out  BUS_WIDTH  fetch address (current PC).
i_IMEM_GNT  in  1  request accepted this cycle; counts only when o_IMEM_REQ=1.
i_IMEM_RVALID  in  1  response data valid; responses arrive in request order, at least 1 cycle after grant.
i_DATA  in  BUS_WIDTH  response instruction word.
i_REDIRECT  in  1  redirect fetch to i_REDIRECT_PC.
i_REDIRECT_PC  in  BUS_WIDTH  redirect target; bits [1:0] ignored and forced to 0.
o_INSTR_VALID  out  1  FIFO head valid.
o_INSTR  out  BUS_WIDTH  FIFO head instruction.
o_INSTR_PC  out  BUS_WIDTH  PC of the FIFO head instruction.
i_INSTR_READY  in  1  decode accepts the head; pop occurs when valid and ready.

Behaviour:
- Reset (i_RST_N=0 at an edge) sets:
  - PC = RESET_VECTOR; resp_pc = RESET_VECTOR.
  - FIFO empty; live_cnt = 0; drop_cnt = 0; state = ST_BOOT.
  - o_IMEM_REQ = 0; o_INSTR_VALID = 0; o_ADDR = RESET_VECTOR.
  - o_INSTR and o_INSTR_PC are don't-care while invalid.
- Reset mid-operation discards everything, including in-flight responses. Memory must also be reset.
- FSM:
  - ST_BOOT: no request. Always goes to ST_FETCH on the next cycle.
  - ST_FETCH: normal operation. Goes to ST_DRAIN on a redirect when stale requests exist, i.e. live_cnt plus this cycle's grant minus this cycle's live response is greater than 0.
  - ST_DRAIN: drop_cnt > 0. Requests are allowed. Goes to ST_FETCH when drop_cnt reaches 0 and no new redirect adds stale requests.
- o_IMEM_REQ depends on registered state only, never on i_REDIRECT:
  - o_IMEM_REQ = (state != ST_BOOT) && (fifo_cnt + live_cnt < FIFO_DEPTH) && (live_cnt + drop_cnt < FIFO_DEPTH).
  - This credit rule guarantees every live response has a FIFO slot. Overflow is impossible; an overflow condition is an assertion failure.
- Grant (o_IMEM_REQ && i_IMEM_GNT): PC <= PC + 4, wrapping modulo 2^BUS_WIDTH; live_cnt increments.
- Response (i_IMEM_RVALID):
  - If drop_cnt > 0: drop_cnt decrements and the data is discarded.
  - Else: push {i_DATA, resp_pc} into the FIFO, resp_pc <= resp_pc + 4, live_cnt decrements.
  - A pushed instruction is visible on o_INSTR_VALID one cycle after the response.
- Pop: the head advances on o_INSTR_VALID && i_INSTR_READY. Simultaneous push and pop keeps fifo_cnt unchanged. Pop on empty is a no-op.
- Redirect (i_REDIRECT=1) has priority over the same-cycle grant, response and pop. Next cycle:
  - PC = resp_pc = {i_REDIRECT_PC[BUS_WIDTH-1:2], 2'b00}.
  - FIFO empty, so o_INSTR_VALID = 0.
  - drop_cnt = drop_cnt + live_cnt + gnt − rvalid_dropped, where gnt and rvalid_dropped are 0 or 1 for this cycle; a same-cycle grant becomes stale.
  - live_cnt = 0.
  - Requests resume from the new PC on the following cycle, subject to the credit rule.
- Back-to-back redirects: each one accumulates stale requests into drop_cnt; the last target wins.
- Counters are $clog2(FIFO_DEPTH)+1 bits wide. live_cnt + drop_cnt never exceeds FIFO_DEPTH.
- o_INSTR and o_INSTR_PC are driven from FIFO storage, with no combinational path from i_DATA.

Test Plan:
- Reset release, memory grants every cycle with 1-cycle latency, ready=1 → o_ADDR 0x0,0x4,0x8,…; o_INSTR_PC matches o_ADDR; first o_INSTR_VALID 3 cycles after reset release.
- i_INSTR_READY=0, FIFO_DEPTH=4, zero-wait memory → exactly 4 grants, then o_IMEM_REQ=0 holding o_ADDR=0x10; ready=1 for 1 cycle → 1 pop then 1 new request at 0x10.
- 3-cycle response latency with 2 requests in flight (0x8, 0xC); redirect to 0x100 → both stale responses discarded, next o_INSTR_PC=0x100, o_INSTR equals the word at 0x100.
- Redirect in the same cycle as a grant, plus a second redirect 1 cycle later to 0x200 → all pre-redirect responses dropped, first delivered o_INSTR_PC=0x200.
- i_REDIRECT_PC=0x103 → o_ADDR=0x100; PC at 0xFFFFFFFC → next o_ADDR=0x00000000.
- Assert i_RST_N=0 mid-stream with outstanding requests → next cycle o_IMEM_REQ=0, o_INSTR_VALID=0, o_ADDR=RESET_VECTOR; fetch restarts cleanly.

Source files
------------

// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: instruction fetch stage.
// Owns the PC and issues in-order fetches under a credit limit. Returned
// words are tagged with their PC and queued toward decode. A redirect
// flushes the queue, and every request still outstanding becomes a
// response that must be dropped when it arrives.

module riscv_fetch_unit_chk #(
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = 3
) (
  input  logic          i_CLK,
  input  logic          i_RST_N,
  input  logic          push_s,
  input  logic          pop_s,
  input  logic [CW-1:0] fifo_cnt_r,
  input  logic [CW-1:0] live_cnt_r,
  input  logic [CW-1:0] drop_cnt_r
);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  // A push into a full buffer without a same-cycle pop means the credit rule broke.
  a_no_overflow: assert property (@(posedge i_CLK) disable iff (!i_RST_N)
    (push_s && !pop_s) |-> ({1'b0, fifo_cnt_r} < DEPTH_W));

  // Live plus stale requests can never exceed the buffer depth.
  a_credit_cap: assert property (@(posedge i_CLK) disable iff (!i_RST_N)
    (({1'b0, live_cnt_r} + {1'b0, drop_cnt_r}) <= DEPTH_W));
endmodule

module riscv_fetch_unit #(
  parameter int                   BUS_WIDTH    = 32,
  parameter logic [BUS_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int                   FIFO_DEPTH   = 4
) (
  input  logic                 i_CLK,
  input  logic                 i_RST_N,
  output logic                 o_IMEM_REQ,
  output logic [BUS_WIDTH-1:0] o_ADDR,
  input  logic                 i_IMEM_GNT,
  input  logic                 i_IMEM_RVALID,
  input  logic [BUS_WIDTH-1:0] i_DATA,
  input  logic                 i_REDIRECT,
  input  logic [BUS_WIDTH-1:0] i_REDIRECT_PC,
  output logic                 o_INSTR_VALID,
  output logic [BUS_WIDTH-1:0] o_INSTR,
  output logic [BUS_WIDTH-1:0] o_INSTR_PC,
  input  logic                 i_INSTR_READY
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]          DEPTH_W    = (CW+1)'(FIFO_DEPTH);
  localparam logic [BUS_WIDTH-1:0] PC_STEP    = BUS_WIDTH'(3'd4);
  localparam logic [BUS_WIDTH-1:0] ALIGN_MASK = ~(BUS_WIDTH'(2'b11));
  localparam logic [AW-1:0]        PTR_ONE    = AW'(1'b1);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Fetch addresses are word aligned; the low two bits are cleared.
  function automatic logic [BUS_WIDTH-1:0] align_pc(input logic [BUS_WIDTH-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

  state_t               state_r, state_nxt_s;
  logic [BUS_WIDTH-1:0] pc_r, pc_nxt_s;
  logic [BUS_WIDTH-1:0] resp_pc_r, resp_pc_nxt_s;
  logic [CW-1:0]        live_cnt_r, live_nxt_s;
  logic [CW-1:0]        drop_cnt_r, drop_nxt_s;
  logic [CW-1:0]        fifo_cnt_r, fifo_cnt_nxt_s;
  logic [AW-1:0]        wr_ptr_r, wr_ptr_nxt_s;
  logic [AW-1:0]        rd_ptr_r, rd_ptr_nxt_s;
  logic                 req_r, req_nxt_s;
  logic                 valid_r, valid_nxt_s;
  logic [BUS_WIDTH-1:0] instr_mem_r [FIFO_DEPTH];
  logic [BUS_WIDTH-1:0] pcq_mem_r   [FIFO_DEPTH];

  logic                 gnt_s;
  logic                 rv_s;
  logic                 rv_drop_s;
  logic                 rv_live_s;
  logic                 push_s;
  logic                 pop_s;
  logic [BUS_WIDTH-1:0] redirect_pc_s;

  assign redirect_pc_s = align_pc(i_REDIRECT_PC);

  // Classify this cycle's handshakes; a redirect cancels the push and the pop.
  always_comb begin
    gnt_s     = req_r & i_IMEM_GNT;
    rv_s      = i_IMEM_RVALID & ((drop_cnt_r != {CW{1'b0}}) | (live_cnt_r != {CW{1'b0}}));
    rv_drop_s = rv_s & (drop_cnt_r != {CW{1'b0}});
    rv_live_s = rv_s & (drop_cnt_r == {CW{1'b0}});
    push_s    = rv_live_s & ~i_REDIRECT;
    pop_s     = valid_r & i_INSTR_READY & ~i_REDIRECT;
  end

  // Next PC, counters and buffer pointers; a redirect overrides everything else.
  always_comb begin
    pc_nxt_s       = pc_r;
    resp_pc_nxt_s  = resp_pc_r;
    live_nxt_s     = live_cnt_r;
    drop_nxt_s     = drop_cnt_r;
    fifo_cnt_nxt_s = fifo_cnt_r;
    wr_ptr_nxt_s   = wr_ptr_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    if (i_REDIRECT) begin
      // Everything requested so far, including a same-cycle grant, is stale;
      // a response arriving this cycle is consumed here.
      pc_nxt_s       = redirect_pc_s;
      resp_pc_nxt_s  = redirect_pc_s;
      live_nxt_s     = {CW{1'b0}};
      drop_nxt_s     = drop_cnt_r + live_cnt_r + CW'(gnt_s) - CW'(rv_s);
      fifo_cnt_nxt_s = {CW{1'b0}};
      wr_ptr_nxt_s   = {AW{1'b0}};
      rd_ptr_nxt_s   = {AW{1'b0}};
    end else begin
      if (gnt_s) begin
        pc_nxt_s = pc_r + PC_STEP;
      end else begin
        pc_nxt_s = pc_r;
      end
      if (push_s) begin
        resp_pc_nxt_s = resp_pc_r + PC_STEP;
        wr_ptr_nxt_s  = wr_ptr_r + PTR_ONE;
      end else begin
        resp_pc_nxt_s = resp_pc_r;
        wr_ptr_nxt_s  = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      live_nxt_s     = live_cnt_r + CW'(gnt_s) - CW'(rv_live_s);
      drop_nxt_s     = drop_cnt_r - CW'(rv_drop_s);
      fifo_cnt_nxt_s = fifo_cnt_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // FSM next state: drain while stale responses remain outstanding.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_BOOT: begin
        state_nxt_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (i_REDIRECT && (drop_nxt_s != {CW{1'b0}})) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (drop_nxt_s == {CW{1'b0}}) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_BOOT;
      end
    endcase
  end

  // Request and head-valid are precomputed from next-state values so both
  // outputs come straight from flops and never see i_REDIRECT combinationally.
  always_comb begin
    req_nxt_s   = (state_nxt_s != ST_BOOT) &&
                  (({1'b0, fifo_cnt_nxt_s} + {1'b0, live_nxt_s}) < DEPTH_W) &&
                  (({1'b0, live_nxt_s} + {1'b0, drop_nxt_s}) < DEPTH_W);
    valid_nxt_s = (fifo_cnt_nxt_s != {CW{1'b0}});
  end

  // Control, PC and counter registers with synchronous active-low reset.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state_r    <= ST_BOOT;
      pc_r       <= RESET_VECTOR;
      resp_pc_r  <= RESET_VECTOR;
      live_cnt_r <= {CW{1'b0}};
      drop_cnt_r <= {CW{1'b0}};
      fifo_cnt_r <= {CW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      req_r      <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      resp_pc_r  <= resp_pc_nxt_s;
      live_cnt_r <= live_nxt_s;
      drop_cnt_r <= drop_nxt_s;
      fifo_cnt_r <= fifo_cnt_nxt_s;
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      req_r      <= req_nxt_s;
      valid_r    <= valid_nxt_s;
    end
  end

  // Buffer storage: each accepted response is written with its PC tag.
  always_ff @(posedge i_CLK) begin
    if (i_RST_N && push_s) begin
      instr_mem_r[wr_ptr_r] <= i_DATA;
      pcq_mem_r[wr_ptr_r]   <= resp_pc_r;
    end
  end

  assign o_IMEM_REQ    = req_r;
  assign o_ADDR        = pc_r;
  assign o_INSTR_VALID = valid_r;
  assign o_INSTR       = instr_mem_r[rd_ptr_r];
  assign o_INSTR_PC    = pcq_mem_r[rd_ptr_r];

  riscv_fetch_unit_chk #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CW         (CW)
  ) u_chk (
    .i_CLK      (i_CLK),
    .i_RST_N    (i_RST_N),
    .push_s     (push_s),
    .pop_s      (pop_s),
    .fifo_cnt_r (fifo_cnt_r),
    .live_cnt_r (live_cnt_r),
    .drop_cnt_r (drop_cnt_r)
  );
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Testbench for riscv_fetch_unit: a behavioural instruction memory with
// configurable latency, directed scenarios that queue hand-computed expected
// instructions, and a monitor that checks every instruction decode accepts.

module tb_riscv_fetch_unit;
  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        ready;

  typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;
  typedef struct { string name; logic [31:0] act; logic [31:0] req; } chk_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  exp_t  exp_q [$];
  chk_t  chk_q [$];
  pend_t pend_q [$];
  int    checks = 0;
  int    failures = 0;
  int    edge_n = 0;
  int    mem_lat = 1;
  int    gnt_total = 0;

  riscv_fetch_unit #(
    .BUS_WIDTH    (32),
    .RESET_VECTOR (32'h0000_0000),
    .FIFO_DEPTH   (4)
  ) dut (
    .i_CLK         (clk),
    .i_RST_N       (rst_n),
    .o_IMEM_REQ    (imem_req),
    .o_ADDR        (addr),
    .i_IMEM_GNT    (gnt),
    .i_IMEM_RVALID (rvalid),
    .i_DATA        (rdata),
    .i_REDIRECT    (redirect),
    .i_REDIRECT_PC (redirect_pc),
    .o_INSTR_VALID (instr_valid),
    .o_INSTR       (instr),
    .o_INSTR_PC    (instr_pc),
    .i_INSTR_READY (ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
    end
  end

  // Instruction memory: records grants at the upcoming edge, answers in order after mem_lat edges.
  initial begin
    int up;
    int due;
    int last_due;
    pend_t p;
    rvalid = 1'b0;
    rdata = 32'h0;
    last_due = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pend_q.delete();
        rvalid = 1'b0;
        last_due = 0;
      end else begin
        up = edge_n + 1;
        if (pend_q.size() > 0 && pend_q[0].due <= up) begin
          p = pend_q.pop_front();
          rvalid = 1'b1;
          rdata = mem_word(p.addr);
        end else begin
          rvalid = 1'b0;
        end
        if (imem_req && gnt) begin
          due = up + mem_lat;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          p.addr = addr;
          p.due = due;
          pend_q.push_back(p);
          gnt_total++;
        end
      end
    end
  end

  // Monitor: sole owner of the counters; runs queued direct checks and scoreboards accepted instructions.
  initial begin
    chk_t c;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        checks++;
        if (c.act !== c.req) begin
          failures++;
          $display("FAIL %s actual=0x%08h required=0x%08h", c.name, c.act, c.req);
        end
      end
      if (rst_n && !redirect && instr_valid && ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_instr actual pc=0x%08h instr=0x%08h required=none", instr_pc, instr);
        end else begin
          e = exp_q.pop_front();
          if (instr_pc !== e.pc || instr !== e.word) begin
            failures++;
            $display("FAIL instr_out actual pc=0x%08h instr=0x%08h required pc=0x%08h instr=0x%08h",
                     instr_pc, instr, e.pc, e.word);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic post_chk(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_t c;
    c.name = name;
    c.act = act;
    c.req = req;
    chk_q.push_back(c);
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    exp_t e;
    logic [31:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      e.pc = a;
      e.word = mem_word(a);
      exp_q.push_back(e);
      a = a + 32'd4;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect = 1'b0;
    ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    post_chk("rst_req", 32'(imem_req), 32'h0);
    post_chk("rst_valid", 32'(instr_valid), 32'h0);
    post_chk("rst_addr", addr, 32'h0000_0000);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int left;
    left = exp_q.size();
    for (int i = 0; i < max_cyc && left != 0; i++) begin
      @(negedge clk);
      left = exp_q.size();
    end
    post_chk(name, 32'(left), 32'h0);
    exp_q.delete();
  endtask

  task automatic wait_addr(input string name, input logic [31:0] target, input int max_cyc);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < max_cyc && !hit; i++) begin
      @(negedge clk);
      hit = (addr == target);
    end
    post_chk(name, addr, target);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    gnt = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    ready = 1'b0;

    // Streaming fetch: grant every cycle, 1-cycle latency, decode always ready.
    mem_lat = 1;
    gnt = 1'b1;
    apply_reset();
    ready = 1'b1;
    expect_seq(32'h0000_0000, 8);
    @(negedge clk);
    post_chk("t1_req_first", 32'(imem_req), 32'h1);
    post_chk("t1_addr0", addr, 32'h0000_0000);
    post_chk("t1_valid_c1", 32'(instr_valid), 32'h0);
    @(negedge clk);
    post_chk("t1_addr1", addr, 32'h0000_0004);
    post_chk("t1_valid_c2", 32'(instr_valid), 32'h0);
    @(negedge clk);
    post_chk("t1_valid_c3", 32'(instr_valid), 32'h1);
    post_chk("t1_addr2", addr, 32'h0000_0008);
    wait_drain("t1_drain", 60);
    ready = 1'b0;

    // Credit limit: decode stalled, exactly FIFO_DEPTH grants, then one pop frees one request.
    mem_lat = 1;
    gnt = 1'b1;
    apply_reset();
    base = gnt_total;
    repeat (12) @(negedge clk);
    post_chk("t2_grants", 32'(gnt_total - base), 32'd4);
    post_chk("t2_req_off", 32'(imem_req), 32'h0);
    post_chk("t2_addr_hold", addr, 32'h0000_0010);
    post_chk("t2_valid", 32'(instr_valid), 32'h1);
    expect_seq(32'h0000_0000, 1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    post_chk("t2_req_again", 32'(imem_req), 32'h1);
    post_chk("t2_addr_again", addr, 32'h0000_0010);
    @(negedge clk);
    post_chk("t2_grants_after", 32'(gnt_total - base), 32'd5);
    post_chk("t2_addr_next", addr, 32'h0000_0014);
    post_chk("t2_pending", 32'(exp_q.size()), 32'h0);

    // Redirect with 0x8 and 0xC in flight at 3-cycle latency.
    mem_lat = 3;
    gnt = 1'b1;
    apply_reset();
    wait_addr("t3_addr_0x10", 32'h0000_0010, 30);
    gnt = 1'b0;
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0100;
    @(negedge clk);
    redirect = 1'b0;
    post_chk("t3_flushed", 32'(instr_valid), 32'h0);
    post_chk("t3_addr_target", addr, 32'h0000_0100);
    gnt = 1'b1;
    ready = 1'b1;
    expect_seq(32'h0000_0100, 3);
    wait_drain("t3_drain", 80);
    ready = 1'b0;

    // Redirect coinciding with a grant, then a second redirect one cycle later.
    mem_lat = 2;
    gnt = 1'b1;
    apply_reset();
    wait_addr("t4_addr_0x8", 32'h0000_0008, 30);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0150;
    @(negedge clk);
    redirect_pc = 32'h0000_0200;
    @(negedge clk);
    redirect = 1'b0;
    post_chk("t4_addr_target", addr, 32'h0000_0200);
    post_chk("t4_flushed", 32'(instr_valid), 32'h0);
    ready = 1'b1;
    expect_seq(32'h0000_0200, 3);
    wait_drain("t4_drain", 80);
    ready = 1'b0;

    // Misaligned redirect target and PC wrap at the top of the address space.
    mem_lat = 1;
    gnt = 1'b0;
    apply_reset();
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    redirect = 1'b0;
    post_chk("t5_align", addr, 32'h0000_0100);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    post_chk("t5_top", addr, 32'hFFFF_FFFC);
    gnt = 1'b1;
    @(negedge clk);
    post_chk("t5_wrap", addr, 32'h0000_0000);
    @(negedge clk);
    gnt = 1'b0;
    post_chk("t5_after_wrap", addr, 32'h0000_0004);
    exp_q.push_back('{pc: 32'hFFFF_FFFC, word: mem_word(32'hFFFF_FFFC)});
    expect_seq(32'h0000_0000, 1);
    ready = 1'b1;
    wait_drain("t5_drain", 40);
    ready = 1'b0;

    // Reset mid-stream with requests outstanding, then a clean restart.
    mem_lat = 3;
    gnt = 1'b1;
    apply_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    post_chk("t6_req", 32'(imem_req), 32'h0);
    post_chk("t6_valid", 32'(instr_valid), 32'h0);
    post_chk("t6_addr", addr, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    expect_seq(32'h0000_0000, 3);
    wait_drain("t6_drain", 60);
    ready = 1'b0;

    repeat (3) @(negedge clk);
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
